// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared types and constants for the ATM session controller
//
// Purpose: state and op enums, bill denominations, default balance limit and
//          the bill validity helper used by atm_session_ctrl.
// Ports:   none (package)
package atm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READY,
        EXEC,
        HOLD,
        CLOSE
    } state_e;

    typedef enum logic {
        DEP,
        WD
    } op_e;

    localparam logic [7:0] BILL_1   = 8'd1;
    localparam logic [7:0] BILL_5   = 8'd5;
    localparam logic [7:0] BILL_10  = 8'd10;
    localparam logic [7:0] BILL_20  = 8'd20;
    localparam logic [7:0] BILL_50  = 8'd50;
    localparam logic [7:0] BILL_100 = 8'd100;

    localparam int DEFAULT_MAX_BALANCE = 9999;

    // A bill is usable only when exactly one switch is up and it decodes to
    // a non-zero value.
    function automatic logic bill_valid(input logic [7:0] amt, input logic err);
        return !err && (amt != 8'd0);
    endfunction

endpackage

// File: rtl/atm_edge_det.sv
// rtl/atm_edge_det.sv - single-bit registered rising-edge detector
//
// Purpose: flags a 0->1 transition of d_i against the previous-cycle sample.
// Ports:   clk    - clock
//          rst    - synchronous active-high reset (history cleared to 0)
//          d_i    - level input
//          rise_o - high in the cycle d_i is 1 and was 0 the cycle before
module atm_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/atm_session_ctrl.sv
// rtl/atm_session_ctrl.sv - ATM session sequencing controller and balance owner
//
// Purpose: runs one card session at a time, applies deposit/withdraw button
//          presses using the decoded bill value, and rejects invalid bills,
//          over-limit deposits and insufficient-funds withdrawals.
// Build option: ATM_SESSION_TIMEOUT_EN compiles in the idle-session timeout.
// Ports:   clk, rst           - clock, synchronous active-high reset
//          card_in            - card present level
//          dep_btn, wd_btn    - debounced deposit / withdraw buttons
//          bill_amount        - selected bill value, 0 if none
//          bill_err           - more than one bill switch up
//          balance            - current balance
//          busy               - high in EXEC, HOLD, CLOSE
//          dispense           - pulse on successful withdraw
//          dispense_amt       - withdrawn amount while dispense is high
//          err_bill, err_ovf,
//          err_nsf, err_cmd   - one-cycle rejection pulses
//          session_done       - pulse while the session is closing
//          timeout            - pulse with session_done on an idle close
module atm_session_ctrl
    import atm_pkg::*;
#(
    parameter int BAL_W       = 16,
    parameter int MAX_BALANCE = DEFAULT_MAX_BALANCE,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             card_in,
    input  logic             dep_btn,
    input  logic             wd_btn,
    input  logic [7:0]       bill_amount,
    input  logic             bill_err,
    output logic [BAL_W-1:0] balance,
    output logic             busy,
    output logic             dispense,
    output logic [7:0]       dispense_amt,
    output logic             err_bill,
    output logic             err_ovf,
    output logic             err_nsf,
    output logic             err_cmd,
    output logic             session_done,
    output logic             timeout
);

    logic card_rise;
    logic dep_rise;
    logic wd_rise;

    atm_edge_det u_card_edge (.clk(clk), .rst(rst), .d_i(card_in), .rise_o(card_rise));
    atm_edge_det u_dep_edge  (.clk(clk), .rst(rst), .d_i(dep_btn), .rise_o(dep_rise));
    atm_edge_det u_wd_edge   (.clk(clk), .rst(rst), .d_i(wd_btn),  .rise_o(wd_rise));

    state_e           state_q;
    op_e              op_q;
    logic [7:0]       amt_q;
    logic             berr_q;
    logic [BAL_W-1:0] balance_q;
    logic             busy_q;
    logic             dispense_q;
    logic [7:0]       dispense_amt_q;
    logic             err_bill_q;
    logic             err_ovf_q;
    logic             err_nsf_q;
    logic             err_cmd_q;
    logic             session_done_q;
    logic             tmo_hit;

`ifdef ATM_SESSION_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] tmo_cnt_q;
    logic             timeout_q;
    logic             tmo_clear;

    // Counting only happens in READY/HOLD. Any button edge restarts the idle
    // window, and leaving HOLD for READY restarts it as a fresh READY entry.
    assign tmo_clear = ((state_q != READY) && (state_q != HOLD)) ||
                       dep_rise || wd_rise ||
                       ((state_q == HOLD) && !dep_btn && !wd_btn);

    always_ff @(posedge clk) begin
        if (rst || tmo_clear) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign timeout = timeout_q;
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^TIMEOUT_CYC;
    assign tmo_hit        = 1'b0;
    assign timeout        = 1'b0;
`endif

    // One extra bit so the over-limit test cannot wrap.
    logic [BAL_W:0] dep_sum;
    assign dep_sum = {1'b0, balance_q} + (BAL_W+1)'(amt_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            op_q           <= DEP;
            amt_q          <= '0;
            berr_q         <= 1'b0;
            balance_q      <= '0;
            busy_q         <= 1'b0;
            dispense_q     <= 1'b0;
            dispense_amt_q <= '0;
            err_bill_q     <= 1'b0;
            err_ovf_q      <= 1'b0;
            err_nsf_q      <= 1'b0;
            err_cmd_q      <= 1'b0;
            session_done_q <= 1'b0;
`ifdef ATM_SESSION_TIMEOUT_EN
            timeout_q      <= 1'b0;
`endif
        end else begin
            dispense_q     <= 1'b0;
            dispense_amt_q <= '0;
            err_bill_q     <= 1'b0;
            err_ovf_q      <= 1'b0;
            err_nsf_q      <= 1'b0;
            err_cmd_q      <= 1'b0;
            session_done_q <= 1'b0;
`ifdef ATM_SESSION_TIMEOUT_EN
            timeout_q      <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (card_rise) begin
                        state_q <= READY;
                    end
                end
                READY: begin
                    if (!card_in) begin
                        state_q        <= CLOSE;
                        busy_q         <= 1'b1;
                        session_done_q <= 1'b1;
                    end else if (dep_rise && wd_rise) begin
                        err_cmd_q <= 1'b1;
                        state_q   <= HOLD;
                        busy_q    <= 1'b1;
                    end else if (dep_rise || wd_rise) begin
                        op_q    <= dep_rise ? DEP : WD;
                        amt_q   <= bill_amount;
                        berr_q  <= bill_err;
                        state_q <= EXEC;
                        busy_q  <= 1'b1;
                    end else if (tmo_hit) begin
                        state_q        <= CLOSE;
                        busy_q         <= 1'b1;
                        session_done_q <= 1'b1;
`ifdef ATM_SESSION_TIMEOUT_EN
                        timeout_q      <= 1'b1;
`endif
                    end
                end
                EXEC: begin
                    if (!bill_valid(amt_q, berr_q)) begin
                        err_bill_q <= 1'b1;
                    end else if (op_q == DEP) begin
                        if (dep_sum > (BAL_W+1)'(MAX_BALANCE)) begin
                            err_ovf_q <= 1'b1;
                        end else begin
                            balance_q <= dep_sum[BAL_W-1:0];
                        end
                    end else if (BAL_W'(amt_q) > balance_q) begin
                        err_nsf_q <= 1'b1;
                    end else begin
                        balance_q      <= balance_q - BAL_W'(amt_q);
                        dispense_q     <= 1'b1;
                        dispense_amt_q <= amt_q;
                    end
                    // The op always completes; card removal only picks the exit.
                    if (card_in) begin
                        state_q <= HOLD;
                    end else begin
                        state_q        <= CLOSE;
                        session_done_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (!card_in) begin
                        state_q        <= CLOSE;
                        session_done_q <= 1'b1;
                    end else if (tmo_hit) begin
                        state_q        <= CLOSE;
                        session_done_q <= 1'b1;
`ifdef ATM_SESSION_TIMEOUT_EN
                        timeout_q      <= 1'b1;
`endif
                    end else if (!dep_btn && !wd_btn) begin
                        state_q <= READY;
                        busy_q  <= 1'b0;
                    end
                end
                CLOSE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign balance      = balance_q;
    assign busy         = busy_q;
    assign dispense     = dispense_q;
    assign dispense_amt = dispense_amt_q;
    assign err_bill     = err_bill_q;
    assign err_ovf      = err_ovf_q;
    assign err_nsf      = err_nsf_q;
    assign err_cmd      = err_cmd_q;
    assign session_done = session_done_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb/tb_atm_session_ctrl.sv - directed self-checking bench for atm_session_ctrl
module tb_atm_session_ctrl;
    import atm_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        card_in = 1'b0;
    logic        dep_btn = 1'b0;
    logic        wd_btn = 1'b0;
    logic [7:0]  bill_amount = 8'd0;
    logic        bill_err = 1'b0;
    logic [15:0] balance;
    logic        busy;
    logic        dispense;
    logic [7:0]  dispense_amt;
    logic        err_bill;
    logic        err_ovf;
    logic        err_nsf;
    logic        err_cmd;
    logic        session_done;
    logic        timeout;
    logic [3:0]  errs;

    int n_pass = 0;
    int n_total = 0;

    assign errs = {err_bill, err_ovf, err_nsf, err_cmd};

    atm_session_ctrl #(
        .BAL_W(16),
        .MAX_BALANCE(9999),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .card_in(card_in),
        .dep_btn(dep_btn),
        .wd_btn(wd_btn),
        .bill_amount(bill_amount),
        .bill_err(bill_err),
        .balance(balance),
        .busy(busy),
        .dispense(dispense),
        .dispense_amt(dispense_amt),
        .err_bill(err_bill),
        .err_ovf(err_ovf),
        .err_nsf(err_nsf),
        .err_cmd(err_cmd),
        .session_done(session_done),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic d, input logic w, input logic [7:0] amt, input logic e);
        @(negedge clk);
        bill_amount = amt;
        bill_err    = e;
        dep_btn     = d;
        wd_btn      = w;
        tick();
    endtask

    task automatic release_btns();
        @(negedge clk);
        dep_btn     = 1'b0;
        wd_btn      = 1'b0;
        bill_amount = 8'd0;
        bill_err    = 1'b0;
        tick();
    endtask

    task automatic open_session();
        @(negedge clk);
        card_in = 1'b1;
        tick();
    endtask

    task automatic close_session();
        @(negedge clk);
        card_in = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_total++;
        if (balance !== 16'd0) $display("FAIL reset_balance: got %0d want 0", balance); else n_pass++;
        n_total++;
        if ({busy, dispense, errs, session_done, timeout} !== 8'd0)
            $display("FAIL reset_flags: got %b want 00000000", {busy, dispense, errs, session_done, timeout});
        else n_pass++;
        n_total++;
        if (dispense_amt !== 8'd0) $display("FAIL reset_dispense_amt: got %0d want 0", dispense_amt); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_deposit();
        open_session();
        press(1'b1, 1'b0, BILL_100, 1'b0);
        n_total++;
        if (balance !== 16'd0) $display("FAIL dep100_early: got %0d want 0", balance); else n_pass++;
        tick();
        n_total++;
        if (balance !== 16'd100) $display("FAIL dep100: got %0d want 100", balance); else n_pass++;
        n_total++;
        if (errs !== 4'd0) $display("FAIL dep100_errs: got %b want 0000", errs); else n_pass++;
        release_btns();
        press(1'b1, 1'b0, BILL_50, 1'b0);
        tick();
        n_total++;
        if (balance !== 16'd150) $display("FAIL dep50: got %0d want 150", balance); else n_pass++;
        release_btns();
        press(1'b1, 1'b0, BILL_5, 1'b0);
        tick();
        n_total++;
        if (balance !== 16'd155) $display("FAIL dep5: got %0d want 155", balance); else n_pass++;
        n_total++;
        if ({busy, errs, dispense} !== 6'b100000) $display("FAIL dep5_flags: got %b want 100000", {busy, errs, dispense}); else n_pass++;
        release_btns();
        n_total++;
        if (busy !== 1'b0) $display("FAIL ready_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_withdraw();
        press(1'b0, 1'b1, BILL_20, 1'b0);
        tick();
        n_total++;
        if (balance !== 16'd135) $display("FAIL wd20: got %0d want 135", balance); else n_pass++;
        n_total++;
        if ({dispense, dispense_amt} !== {1'b1, 8'd20}) $display("FAIL wd20_dispense: got %b/%0d want 1/20", dispense, dispense_amt); else n_pass++;
        tick();
        n_total++;
        if ({dispense, dispense_amt} !== 9'd0) $display("FAIL wd20_pulse_end: got %b/%0d want 0/0", dispense, dispense_amt); else n_pass++;
        release_btns();
        press(1'b0, 1'b1, BILL_100, 1'b0);
        tick();
        n_total++;
        if (balance !== 16'd35) $display("FAIL wd100: got %0d want 35", balance); else n_pass++;
        release_btns();
        press(1'b0, 1'b1, BILL_100, 1'b0);
        tick();
        n_total++;
        if (balance !== 16'd35) $display("FAIL nsf_balance: got %0d want 35", balance); else n_pass++;
        n_total++;
        if ({errs, dispense} !== 5'b00100) $display("FAIL nsf_flags: got %b want 00100", {errs, dispense}); else n_pass++;
        release_btns();
        close_session();
    endtask

    task automatic test_overflow_bill();
        logic [7:0] top_up [7];
        top_up = '{BILL_20, BILL_20, BILL_5, BILL_1, BILL_1, BILL_1, BILL_1};
        open_session();
        repeat (99) begin
            press(1'b1, 1'b0, BILL_100, 1'b0);
            tick();
            release_btns();
        end
        press(1'b1, 1'b0, BILL_10, 1'b0); tick(); release_btns();
        press(1'b1, 1'b0, BILL_5, 1'b0);  tick(); release_btns();
        n_total++;
        if (balance !== 16'd9950) $display("FAIL fill_9950: got %0d want 9950", balance); else n_pass++;
        press(1'b1, 1'b0, BILL_100, 1'b0);
        tick();
        n_total++;
        if ({balance, errs} !== {16'd9950, 4'b0100}) $display("FAIL ovf100: got %0d/%b want 9950/0100", balance, errs); else n_pass++;
        release_btns();
        press(1'b1, 1'b0, BILL_20, 1'b1);
        tick();
        n_total++;
        if ({balance, errs} !== {16'd9950, 4'b1000}) $display("FAIL bill_err: got %0d/%b want 9950/1000", balance, errs); else n_pass++;
        release_btns();
        press(1'b1, 1'b0, 8'd0, 1'b0);
        tick();
        n_total++;
        if ({balance, errs} !== {16'd9950, 4'b1000}) $display("FAIL bill_zero: got %0d/%b want 9950/1000", balance, errs); else n_pass++;
        release_btns();
        for (int i = 0; i < 7; i++) begin
            press(1'b1, 1'b0, top_up[i], 1'b0);
            tick();
            release_btns();
        end
        n_total++;
        if ({balance, errs} !== {16'd9999, 4'b0000}) $display("FAIL exact_max: got %0d/%b want 9999/0000", balance, errs); else n_pass++;
        press(1'b1, 1'b0, BILL_1, 1'b0);
        tick();
        n_total++;
        if ({balance, errs} !== {16'd9999, 4'b0100}) $display("FAIL ovf_by_1: got %0d/%b want 9999/0100", balance, errs); else n_pass++;
        release_btns();
        press(1'b0, 1'b1, BILL_50, 1'b1);
        tick();
        n_total++;
        if ({balance, errs, dispense} !== {16'd9999, 5'b10000}) $display("FAIL wd_bill_err: got %0d/%b/%b want 9999/1000/0", balance, errs, dispense); else n_pass++;
        release_btns();
        close_session();
    endtask

    task automatic test_cmd_err_hold();
        open_session();
        press(1'b1, 1'b1, BILL_50, 1'b0);
        n_total++;
        if ({err_cmd, busy} !== 2'b11) $display("FAIL cmd_err: got err_cmd=%b busy=%b want 1/1", err_cmd, busy); else n_pass++;
        tick();
        n_total++;
        if ({balance, errs} !== {16'd9999, 4'b0000}) $display("FAIL cmd_err_after: got %0d/%b want 9999/0000", balance, errs); else n_pass++;
        release_btns();
        press(1'b0, 1'b1, BILL_100, 1'b0);
        tick();
        release_btns();
        press(1'b1, 1'b0, BILL_1, 1'b0);
        repeat (50) tick();
        n_total++;
        if (balance !== 16'd9900) $display("FAIL held_once: got %0d want 9900", balance); else n_pass++;
        release_btns();
        close_session();
    endtask

    task automatic test_card_drop();
        open_session();
        press(1'b1, 1'b0, BILL_10, 1'b0);
        @(negedge clk);
        card_in = 1'b0;
        tick();
        n_total++;
        if ({balance, session_done, busy} !== {16'd9910, 2'b11}) $display("FAIL drop_exec: got %0d/%b/%b want 9910/1/1", balance, session_done, busy); else n_pass++;
        @(negedge clk);
        card_in = 1'b1;
        tick();
        n_total++;
        if ({session_done, busy} !== 2'b00) $display("FAIL drop_idle: got %b/%b want 0/0", session_done, busy); else n_pass++;
        release_btns();
        press(1'b1, 1'b0, BILL_5, 1'b0);
        tick();
        n_total++;
        if ({balance, busy} !== {16'd9910, 1'b0}) $display("FAIL card_left_high: got %0d/%b want 9910/0", balance, busy); else n_pass++;
        release_btns();
        close_session();
    endtask

    task automatic test_timeout();
        open_session();
        repeat (7) tick();
        n_total++;
        if ({session_done, timeout} !== 2'b00) $display("FAIL tmo_early: got %b/%b want 0/0", session_done, timeout); else n_pass++;
        tick();
`ifdef ATM_SESSION_TIMEOUT_EN
        n_total++;
        if ({session_done, timeout} !== 2'b11) $display("FAIL tmo_fire: got %b/%b want 1/1", session_done, timeout); else n_pass++;
        tick();
        n_total++;
        if ({session_done, timeout, busy} !== 3'b000) $display("FAIL tmo_idle: got %b/%b/%b want 0/0/0", session_done, timeout, busy); else n_pass++;
        press(1'b1, 1'b0, BILL_1, 1'b0);
        tick();
        n_total++;
        if (balance !== 16'd9910) $display("FAIL tmo_no_op: got %0d want 9910", balance); else n_pass++;
`else
        n_total++;
        if ({session_done, timeout} !== 2'b00) $display("FAIL no_tmo: got %b/%b want 0/0", session_done, timeout); else n_pass++;
        press(1'b1, 1'b0, BILL_1, 1'b0);
        tick();
        n_total++;
        if (balance !== 16'd9911) $display("FAIL still_ready: got %0d want 9911", balance); else n_pass++;
`endif
        release_btns();
        close_session();
    endtask

    task automatic test_reset_midop();
        open_session();
        press(1'b1, 1'b0, BILL_50, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        n_total++;
        if ({balance, busy, errs, dispense, session_done} !== 23'd0)
            $display("FAIL reset_midop: got bal=%0d flags=%b want 0/0", balance, {busy, errs, dispense, session_done});
        else n_pass++;
        @(negedge clk);
        rst     = 1'b0;
        card_in = 1'b0;
        release_btns();
    endtask

    initial begin
        test_reset();
        test_deposit();
        test_withdraw();
        test_overflow_bill();
        test_cmd_err_hold();
        test_card_drop();
        test_timeout();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/atm_session_ctrl.md
# atm_session_ctrl

Sequencing controller for the ATM bill path: owns the account balance and runs one customer session at a time. Each deposit or withdraw button press consumes the single-bill value from the bill decoder (denominations $1/$5/$10/$20/$50/$100 plus a multi-switch error flag) and applies it to the balance. Over-limit, insufficient-funds and invalid-bill commands are rejected with one-cycle error pulses. Sits between the switch/bill decoder and the display/dispense logic.

## Interface
- BAL_W, 16, balance width in bits; must be ≥ 8
- MAX_BALANCE, 9999, largest legal balance; must fit in BAL_W bits
- TIMEOUT_CYC, 1000, idle cycles in a session before forced close; must be ≥ 2
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- card_in  in  1  level, card present
- dep_btn  in  1  level, deposit button, already debounced
- wd_btn  in  1  level, withdraw button, already debounced
- bill_amount  in  8  dollar value of the selected bill, 0 if none
- bill_err  in  1  high when more than one bill switch is up
- balance  out  BAL_W  current balance (registered)
- busy  out  1  high in EXEC, HOLD, CLOSE
- dispense  out  1  one-cycle pulse on successful withdraw
- dispense_amt  out  8  amount withdrawn, valid while dispense is high, 0 otherwise
- err_bill  out  1  one-cycle pulse: bill_err was high or bill_amount was 0 at command capture
- err_ovf  out  1  one-cycle pulse: deposit would exceed MAX_BALANCE
- err_nsf  out  1  one-cycle pulse: withdraw exceeds balance
- err_cmd  out  1  one-cycle pulse: dep and wd rising edges in the same cycle
- session_done  out  1  one-cycle pulse on session close
- timeout  out  1  one-cycle pulse, coincident with session_done, when closed by timeout

## Operation
- Rising edges are detected on card_in, dep_btn and wd_btn against the previous-cycle sample; edge-detect registers reset to 0.
- States: IDLE, READY, EXEC, HOLD, CLOSE. Reset state is IDLE.
- IDLE: buttons are ignored. A card_in rising edge moves to READY and clears the timeout counter. A card left inserted after a close does not reopen a session.
- READY:
  - card_in low moves to CLOSE.
  - Exactly one button edge moves to EXEC and latches the op (DEP/WD) and bill_amount/bill_err from that same cycle.
  - Both edges in the same cycle: err_cmd pulse, no balance change, move to HOLD.
- EXEC (1 cycle): the latched op is checked in this order:
  - Invalid bill: err_bill.
  - DEP with balance + amount > MAX_BALANCE (compare at BAL_W+1 bits): err_ovf.
  - WD with amount > balance: err_nsf.
  - Otherwise the balance is updated and a WD raises dispense with dispense_amt = amount.
  - A rejected op never changes the balance. EXEC moves to HOLD, or to CLOSE if card_in is low.
- HOLD: waits until dep_btn and wd_btn are both low, then returns to READY. card_in low moves to CLOSE.
- CLOSE (1 cycle): session_done pulse, then IDLE.
- The balance persists across sessions. Only rst clears it.
- Reset values: balance 0, dispense_amt 0, every pulse output 0, busy 0.

## Timing
- Button high in cycle N (low in N-1), state READY: EXEC in N+1. Balance, dispense and error outputs update at the N+2 edge and are visible in N+2 for one cycle (pulses).
- Throughput: at most one command per button press. A held button never repeats.
- card_in falls during EXEC: the op still completes, then CLOSE. card_in falls in READY or HOLD: CLOSE on the next cycle. No op is applied.
- rst has priority over everything, in any state, mid-command included: any in-flight op is dropped.
- Timeout: in READY and HOLD the counter increments every cycle. It clears on entry to READY and on any command edge. At TIMEOUT_CYC-1 the FSM moves to CLOSE, and timeout is pulsed together with session_done.

## Configuration
- ATM_SESSION_TIMEOUT_EN defined: the timeout counter, the timeout port behaviour and forced close are compiled in.
- Not defined: the counter is not built, the timeout port is tied to 0, and sessions end only on card removal.

## Structure
- atm_pkg holds:
  - the state enum (IDLE/READY/EXEC/HOLD/CLOSE);
  - the op enum (DEP/WD);
  - denomination constants BILL_1/5/10/20/50/100;
  - the default MAX_BALANCE.
- One sub-module, atm_edge_det: a single-bit registered rising-edge detector, instantiated three times (card_in, dep_btn, wd_btn).

## Test plan
- Reset, card edge, deposit $100, $50, $5 -> balance 100, 150, 155, each update 2 cycles after the press. No error pulses.
- Balance 155, withdraw $20 -> balance 135, dispense pulse with dispense_amt 20. Then withdraw $100 twice -> balance 35, then err_nsf with balance held at 35.
- Balance 9950, deposit $100 -> err_ovf, balance 9950. Deposit $20 with bill_err high -> err_bill, balance unchanged.
- dep_btn and wd_btn rise in the same cycle -> err_cmd pulse, no balance change. Held dep_btn for 50 cycles -> exactly one deposit.
- card_in drops in the EXEC cycle of a $10 deposit -> balance +10, session_done the next cycle. Card left high -> the FSM stays in IDLE.
- With ATM_SESSION_TIMEOUT_EN and TIMEOUT_CYC=8: no input for 8 cycles in READY -> timeout and session_done pulses, then IDLE. Without the macro -> the FSM stays in READY.
